// File: rtl/v2f_alu_arbiter.sv
// v2f_alu_arbiter: round-robin issue arbiter sharing one pipelined v2f ALU
// between N_REQ requesters. Each result returns tagged with its requester.
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_op/req_a/req_b
// are the requester side (packed, requester i at slice i); alu_issue/alu_op/
// alu_a/alu_b/alu_y are the shared ALU side; rsp_valid/rsp_id/rsp_y/rsp_err
// carry the single-cycle tagged response.
// Optional: define V2F_ARB_DIVZERO_GUARD_EN to suppress div/mod by zero.
module v2f_alu_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int OP_W    = 4,
    parameter int LATENCY = 2,
    localparam int IDW    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*OP_W-1:0]  req_op,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   alu_issue,
    output logic [OP_W-1:0]        alu_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    input  logic [WIDTH-1:0]       alu_y,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_y,
    output logic                   rsp_err
);

    logic [IDW-1:0]   ptr;
    logic             found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   ptr_next;
    logic [OP_W-1:0]  g_op;
    logic [WIDTH-1:0] g_a;
    logic [WIDTH-1:0] g_b;
    logic             div0;

    // Issue-stage tag, aligned with alu_issue.
    logic             iss_v;
    logic [IDW-1:0]   iss_id;
    logic             iss_err;

    // Tag pipe: last stage lines up with alu_y for the matching issue.
    logic [LATENCY-1:0] tag_v;
    logic [LATENCY-1:0] tag_err;
    logic [IDW-1:0]     tag_id [LATENCY];

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % N_REQ]) begin
                found     = 1'b1;
                grant_idx = IDW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found) req_ready[grant_idx] = 1'b1;
    end

    assign ptr_next = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    assign g_op     = req_op[grant_idx*OP_W +: OP_W];
    assign g_a      = req_a[grant_idx*WIDTH +: WIDTH];
    assign g_b      = req_b[grant_idx*WIDTH +: WIDTH];

`ifdef V2F_ARB_DIVZERO_GUARD_EN
    assign div0 = ((g_op == OP_W'(3)) || (g_op == OP_W'(4))) && (g_b == '0);
`else
    assign div0 = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            alu_issue <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            iss_v     <= 1'b0;
            iss_id    <= '0;
            iss_err   <= 1'b0;
            tag_v     <= '0;
            tag_err   <= '0;
            for (int k = 0; k < LATENCY; k++) tag_id[k] <= '0;
        end else begin
            alu_issue <= found & ~div0;
            iss_v     <= found;
            iss_id    <= grant_idx;
            iss_err   <= found & div0;
            if (found) begin
                ptr <= ptr_next;
                // A suppressed div/mod leaves the ALU inputs untouched.
                if (!div0) begin
                    alu_op <= g_op;
                    alu_a  <= g_a;
                    alu_b  <= g_b;
                end
            end
            for (int k = LATENCY - 1; k > 0; k--) begin
                tag_v[k]   <= tag_v[k-1];
                tag_err[k] <= tag_err[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
            tag_v[0]   <= iss_v;
            tag_err[0] <= iss_err;
            tag_id[0]  <= iss_id;
        end
    end

    assign rsp_valid = tag_v[LATENCY-1];
    assign rsp_err   = tag_v[LATENCY-1] & tag_err[LATENCY-1];
    assign rsp_id    = tag_v[LATENCY-1] ? tag_id[LATENCY-1] : '0;
    assign rsp_y     = (tag_v[LATENCY-1] && !tag_err[LATENCY-1]) ? alu_y : '0;

endmodule

// File: tb/tb_v2f_alu_arbiter.sv
// tb_v2f_alu_arbiter: directed bench for v2f_alu_arbiter with a
// behavioural fixed-latency ALU model.
module tb_v2f_alu_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int OW  = 4;
    localparam int LAT = 2;
    localparam int IDW = $clog2(N);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*OW-1:0]  req_op = '0;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic             alu_issue;
    logic [OW-1:0]    alu_op;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [W-1:0]     alu_y;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_y;
    logic             rsp_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    v2f_alu_arbiter #(
        .N_REQ(N), .WIDTH(W), .OP_W(OW), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_issue(alu_issue), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_err(rsp_err)
    );

    function automatic logic [W-1:0] alu_f(
        input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a * b;
            4'd3: return (b == 0) ? '1 : a / b;
            4'd4: return (b == 0) ? a : a % b;
            4'd5: return a ^ b;
            4'd6: return a & b;
            4'd7: return a | b;
            default: return '0;
        endcase
    endfunction

    // Unissued slots carry a marker value so leakage into rsp_y is visible.
    logic [W-1:0] alu_pipe [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) alu_pipe[k] <= alu_pipe[k-1];
        alu_pipe[0] <= alu_issue ? alu_f(alu_op, alu_a, alu_b) : 32'hDEAD_BEEF;
    end
    assign alu_y = alu_pipe[LAT-1];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [OW-1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        req_op[i*OW +: OW] = op;
        req_a[i*W +: W]    = a;
        req_b[i*W +: W]    = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One isolated request from requester i; checks grant, issue and response.
    task automatic run_single(input int i, input logic [OW-1:0] op,
                              input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic exp_issue, input logic [W-1:0] exp_y,
                              input logic exp_err);
        set_req(i, op, a, b);
        req_valid = N'(1) << i;
        #1;
        check("single_rdy", req_ready, N'(1) << i);
        tick();
        req_valid = '0;
        check("single_issue", alu_issue, exp_issue);
        if (exp_issue) begin
            check("single_op", alu_op, op);
            check("single_a", alu_a, a);
            check("single_b", alu_b, b);
        end
        tick();
        check("single_early", rsp_valid, 0);
        tick();
        check("single_rv", rsp_valid, 1);
        check("single_id", rsp_id, i);
        check("single_y", rsp_y, exp_y);
        check("single_err", rsp_err, exp_err);
        tick();
        check("single_after", rsp_valid, 0);
    endtask

    initial begin
        int nrsp;

        // Reset state
        do_reset();
        check("rst_rdy", req_ready, 0);
        check("rst_issue", alu_issue, 0);
        check("rst_op", alu_op, 0);
        check("rst_a", alu_a, 0);
        check("rst_b", alu_b, 0);
        check("rst_rv", rsp_valid, 0);
        check("rst_id", rsp_id, 0);
        check("rst_err", rsp_err, 0);
        check("rst_y", rsp_y, 0);

        // 1: single add
        run_single(0, 4'd0, 32'd5, 32'd7, 1'b1, 32'd12, 1'b0);

        // 2: all requesters valid, cyclic grants, in-order responses
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 4'd0, 32'(10 * i), 32'd1);
        for (int c = 0; c < 11; c++) begin
            if (c >= 1 && c <= 8) check("t2_issue", alu_issue, 1);
            if (c >= 3) begin
                check("t2_rv", rsp_valid, 1);
                check("t2_id", rsp_id, (c - 3) % N);
                check("t2_y", rsp_y, 10 * ((c - 3) % N) + 1);
            end
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) check("t2_rdy", req_ready, 4'b1 << (c % N));
            tick();
        end

        // 3: grant 2 moves ptr to 3; lone req1 still wins via wrap
        set_req(2, 4'd1, 32'd20, 32'd5);
        req_valid = 4'b0100;
        #1;
        check("t3_rdy2", req_ready, 4'b0100);
        tick();
        check("t3_a2", alu_a, 20);
        set_req(1, 4'd2, 32'd6, 32'd7);
        req_valid = 4'b0010;
        #1;
        check("t3_rdy1", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        check("t3_op1", alu_op, 2);
        check("t3_iss1", alu_issue, 1);
        tick();
        check("t3_rv2", rsp_valid, 1);
        check("t3_id2", rsp_id, 2);
        check("t3_y2", rsp_y, 15);
        tick();
        check("t3_rv1", rsp_valid, 1);
        check("t3_id1", rsp_id, 1);
        check("t3_y1", rsp_y, 42);
        tick();

        // 4: reset with two requests in flight
        set_req(0, 4'd0, 32'd1, 32'd1);
        req_valid = 4'b0001;
        #1;
        tick();
        set_req(1, 4'd0, 32'd2, 32'd2);
        req_valid = 4'b0010;
        #1;
        tick();
        req_valid = '0;
        check("t4_iss", alu_issue, 1);
        rst = 1'b1;
        #1;
        check("t4_iss_rst", alu_issue, 0);
        check("t4_rv_rst", rsp_valid, 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("t4_rv", rsp_valid, 0);
            check("t4_y", rsp_y, 0);
            check("t4_iss0", alu_issue, 0);
            tick();
        end
        req_valid = 4'hF;
        #1;
        check("t4_ptr0", req_ready, 4'b0001);
        req_valid = '0;
        #1;

        // 6: req3 pulses once while req0 holds; req3 never granted
        set_req(0, 4'd5, 32'hF0, 32'h0F);
        set_req(3, 4'd7, 32'h1, 32'h2);
        req_valid = 4'b1001;
        #1;
        check("t6_rdy_a", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0001;
        #1;
        check("t6_rdy_b", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        nrsp = 0;
        for (int c = 0; c < 5; c++) begin
            if (rsp_valid) begin
                nrsp++;
                check("t6_id", rsp_id, 0);
                check("t6_y", rsp_y, 32'hFF);
            end
            tick();
        end
        check("t6_count", nrsp, 2);

        // 5: div/mod handling
`ifdef V2F_ARB_DIVZERO_GUARD_EN
        run_single(2, 4'd3, 32'd9, 32'd0, 1'b0, 32'd0, 1'b1);
`endif
        run_single(2, 4'd3, 32'd9, 32'd3, 1'b1, 32'd3, 1'b0);
        run_single(3, 4'd4, 32'd10, 32'd4, 1'b1, 32'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
